// File: rtl/joybus_host_xfer.sv
// joybus_host_xfer: Joybus host engine that sends a command plus the console stop bit
// on the open-drain line, then captures a variable-length response with timeout.
module joybus_host_xfer #(
    parameter int CLK_FREQ_HZ  = 25000000,
    parameter int MAX_TX_BYTES = 3,
    parameter int MAX_RX_BYTES = 4,
    parameter int TIMEOUT_US   = 64,
    localparam int TW = $clog2(MAX_TX_BYTES + 1),
    localparam int RW = $clog2(MAX_RX_BYTES + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [8*MAX_TX_BYTES-1:0] tx_buf,
    input  logic [TW-1:0]             tx_len,
    input  logic [RW-1:0]             rx_len,
    input  logic                      JB_RX,
    output logic                      JB_TX,
    output logic                      busy,
    output logic                      done,
    output logic                      timeout_err,
    output logic [8*MAX_RX_BYTES-1:0] rx_buf,
    output logic [RW-1:0]             rx_count
);
    localparam int US_CYC = CLK_FREQ_HZ / 1000000;
    localparam int TO_CYC = TIMEOUT_US * US_CYC;
    localparam int CW = $clog2((TO_CYC > 4*US_CYC ? TO_CYC : 4*US_CYC) + 1);
    localparam int TB = 8 * MAX_TX_BYTES;
    localparam int BW = $clog2(TB + 1);
    localparam logic [CW-1:0] C1 = CW'(US_CYC);
    localparam logic [CW-1:0] C2 = CW'(2*US_CYC);
    localparam logic [CW-1:0] C3 = CW'(3*US_CYC);
    localparam logic [CW-1:0] CT = CW'(TO_CYC);

    typedef enum logic [3:0] {
        IDLE, TX_LOW, TX_HIGH, STOP_LOW, STOP_HIGH, RX_WAIT, RX_SAMPLE, RX_RISE, DONE
    } state_t;

    state_t state, state_n;
    logic [CW-1:0] cnt, lim;
    logic [TB-1:0] sh, tx_ord;
    logic [BW-1:0] bits_left;
    logic [TW-1:0] tx_len_c;
    logic [RW-1:0] rx_len_c, rx_len_q;
    logic [6:0] rx_sh;
    logic [2:0] rx_bit;
    logic [1:0] sync;
    logic s, s_d, fall, expire, accept, to_hit;

    // Byte 0 lands in the top of the shift register so the wire order is a plain MSB shift.
    for (genvar i = 0; i < MAX_TX_BYTES; i++) begin : g_ord
        assign tx_ord[TB-8-8*i +: 8] = tx_buf[8*i +: 8];
    end

    assign tx_len_c = tx_len > TW'(MAX_TX_BYTES) ? TW'(MAX_TX_BYTES) : tx_len;
    assign rx_len_c = rx_len > RW'(MAX_RX_BYTES) ? RW'(MAX_RX_BYTES) : rx_len;
    assign s        = sync[1];
    assign fall     = s_d & ~s;
    assign accept   = start && tx_len != '0;
    assign lim      = state == TX_LOW  ? (sh[TB-1] ? C1 : C3) :
                      state == TX_HIGH ? (sh[TB-1] ? C3 : C1) :
                      state == STOP_LOW ? C1 :
                      (state == STOP_HIGH || state == RX_SAMPLE) ? C2 : CT;
    assign expire   = cnt == lim - 1'b1;
    assign to_hit   = expire && ((state == RX_WAIT && !fall) || (state == RX_RISE && !s));
    assign busy     = state != IDLE && state != DONE;
    assign done     = state == DONE;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:      if (accept) state_n = TX_LOW;
            TX_LOW:    if (expire) state_n = TX_HIGH;
            TX_HIGH:   if (expire) state_n = bits_left == BW'(1) ? STOP_LOW : TX_LOW;
            STOP_LOW:  if (expire) state_n = STOP_HIGH;
            STOP_HIGH: if (expire) state_n = rx_len_q == '0 ? DONE : RX_WAIT;
            RX_WAIT:   if (fall) state_n = RX_SAMPLE;
                       else if (expire) state_n = DONE;
            RX_SAMPLE: if (expire) state_n = RX_RISE;
            RX_RISE:   if (s) state_n = rx_count == rx_len_q ? DONE : RX_WAIT;
                       else if (expire) state_n = DONE;
            default:   state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            sh          <= '0;
            bits_left   <= '0;
            rx_len_q    <= '0;
            rx_sh       <= '0;
            rx_bit      <= '0;
            sync        <= 2'b11;
            s_d         <= 1'b1;
            JB_TX       <= 1'b1;
            timeout_err <= 1'b0;
            rx_buf      <= '0;
            rx_count    <= '0;
        end else begin
            state <= state_n;
            cnt   <= state_n != state ? '0 : cnt + 1'b1;
            sync  <= {sync[0], JB_RX};
            s_d   <= s;
            JB_TX <= !(state_n == TX_LOW || state_n == STOP_LOW);
            if (to_hit)
                timeout_err <= 1'b1;
            if (state == IDLE && accept) begin
                sh          <= tx_ord;
                bits_left   <= BW'({tx_len_c, 3'b000});
                rx_len_q    <= rx_len_c;
                rx_bit      <= '0;
                timeout_err <= 1'b0;
                rx_buf      <= '0;
                rx_count    <= '0;
            end
            if (state == TX_HIGH && expire) begin
                sh        <= sh << 1;
                bits_left <= bits_left - 1'b1;
            end
            if (state == RX_SAMPLE && expire) begin
                rx_sh  <= {rx_sh[5:0], s};
                rx_bit <= rx_bit + 1'b1;
                if (rx_bit == 3'd7) begin
                    rx_buf[8*rx_count +: 8] <= {rx_sh, s};
                    rx_count                <= rx_count + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_joybus_host_xfer.sv
// tb_joybus_host_xfer: randomized bench with a wire-level device model and a
// timing-rule reference for the host waveform and response results.
module tb_joybus_host_xfer;
    localparam int US = 25;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, dev_drv = 1'b1;
    logic [23:0] tx_buf = '0;
    logic [1:0] tx_len = '0;
    logic [2:0] rx_len = '0;
    logic JB_RX, JB_TX, busy, done, timeout_err;
    logic [31:0] rx_buf;
    logic [2:0] rx_count;
    int total = 0, passed = 0;
    int last_cnt;
    logic [31:0] last_buf;
    logic last_to;

    assign JB_RX = JB_TX & dev_drv;
    always #5 clk = ~clk;

    joybus_host_xfer #(
        .CLK_FREQ_HZ(25000000), .MAX_TX_BYTES(3), .MAX_RX_BYTES(4), .TIMEOUT_US(64)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .tx_buf(tx_buf), .tx_len(tx_len),
        .rx_len(rx_len), .JB_RX(JB_RX), .JB_TX(JB_TX), .busy(busy), .done(done),
        .timeout_err(timeout_err), .rx_buf(rx_buf), .rx_count(rx_count)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Line level k cycles after the accepting edge: 100-cycle bit cells, then a 75-cycle stop bit.
    function automatic logic tx_level(input logic [23:0] cmd, input int n, input int k);
        int b, off;
        logic bv;
        b = (k - 1) / (4*US);
        off = (k - 1) % (4*US);
        if (b < 8*n) begin
            bv = cmd[8*(b/8) + 7 - b%8];
            return off >= (bv ? US : 3*US);
        end
        return off >= US;
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic dev_send(input int d, input logic [31:0] db);
        logic bv;
        wait_cyc(2*US);
        for (int i = 0; i < d; i++)
            for (int j = 7; j >= 0; j--) begin
                bv = db[8*i+j];
                dev_drv = 1'b0;
                wait_cyc(bv ? US : 3*US);
                dev_drv = 1'b1;
                wait_cyc(bv ? 3*US : US);
            end
        dev_drv = 1'b0;
        wait_cyc(2*US);
        dev_drv = 1'b1;
        wait_cyc(2*US);
    endtask

    task automatic run_txn(input logic [23:0] cmd, input int n, input int rl, input int d,
                           input logic [31:0] db, input bit poke, output int done_k);
        int r, t;
        logic [31:0] eb;
        r = rl > 4 ? 4 : rl;
        t = 800*n + 75;
        eb = '0;
        for (int i = 0; i < d && i < r; i++) eb[8*i +: 8] = db[8*i +: 8];
        last_cnt = d;
        last_buf = eb;
        last_to = d < r;
        done_k = -1;
        @(negedge clk);
        tx_buf = cmd;
        tx_len = n[1:0];
        rx_len = rl[2:0];
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        fork
            if (d > 0) begin
                repeat (t) @(posedge clk);
                dev_send(d, db);
            end
            begin
                for (int k = 1; k < t + 20000; k++) begin
                    if (k <= t) chk("tx_wave", JB_TX, tx_level(cmd, n, k));
                    else chk("rx_line_released", JB_TX, 1);
                    if (done === 1'b1) begin
                        done_k = k;
                        chk("busy_at_done", busy, 0);
                        break;
                    end
                    chk("busy", busy, 1);
                    if (poke && k == 300) begin
                        start = 1'b1;
                        tx_len = 2'($urandom_range(1, 3));
                        tx_buf = 24'($urandom);
                    end
                    if (k == 301) start = 1'b0;
                    @(posedge clk);
                    #1;
                end
                total++;
                if (done_k < 0) $display("FAIL done_wait: no done within %0d cycles", t + 20000);
                else begin
                    passed++;
                    chk("done_after_tx", done_k > t, 1);
                    chk("rx_count", rx_count, d);
                    chk("timeout_err", timeout_err, d < r);
                    chk("rx_buf", rx_buf, eb);
                    if (r == 0) chk("done_cycle_norx", done_k, t + 1);
                    else if (d == 0) chk("done_cycle_silent", done_k, t + 1 + 64*US);
                    @(posedge clk);
                    #1;
                    chk("done_single_pulse", done, 0);
                    chk("idle_busy", busy, 0);
                    chk("idle_line", JB_TX, 1);
                end
            end
        join
    endtask

    initial begin
        int dk, n, rl, r, d;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_jb_tx", JB_TX, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_timeout", timeout_err, 0);
        chk("rst_rx_buf", rx_buf, 0);
        chk("rst_rx_count", rx_count, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        run_txn(24'h000000, 1, 0, 0, 32'h0, 0, dk);
        chk("t1_done_cycle", dk, 876);
        chk("t1_rx_count", rx_count, 0);
        run_txn(24'h000001, 1, 3, 3, 32'h00020005, 1, dk);
        chk("t2_rx_buf", rx_buf[23:0], 24'h020005);
        chk("t2_timeout", timeout_err, 0);
        run_txn(24'h0000FF, 1, 4, 0, 32'h0, 0, dk);
        chk("t3_done_cycle", dk, 2476);
        chk("t3_timeout", timeout_err, 1);
        run_txn(24'h0000A5, 1, 4, 2, 32'h000055AA, 0, dk);
        chk("t4_rx_buf", rx_buf[15:0], 16'h55AA);
        chk("t4_rx_count", rx_count, 2);
        chk("t4_timeout", timeout_err, 1);

        @(negedge clk);
        tx_len = 2'd0;
        tx_buf = 24'hFFFFFF;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k < 200; k++) begin
            chk("zero_len_busy", busy, 0);
            chk("zero_len_line", JB_TX, 1);
            @(posedge clk);
            #1;
        end
        chk("hold_rx_count", rx_count, last_cnt);
        chk("hold_rx_buf", rx_buf, last_buf);
        chk("hold_timeout", timeout_err, last_to);

        @(negedge clk);
        tx_buf = 24'h018002;
        tx_len = 2'd3;
        rx_len = 3'd0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k <= 1010; k++) begin
            chk("rst_run_wave", JB_TX, tx_level(24'h018002, 3, k));
            if (k < 1010) begin
                @(posedge clk);
                #1;
            end
        end
        chk("pre_rst_low", JB_TX, 0);
        #5 rst = 1'b1;
        #1;
        chk("midrst_line", JB_TX, 1);
        chk("midrst_busy", busy, 0);
        for (int k = 0; k < 8; k++) begin
            if (k == 3) begin
                @(negedge clk);
                rst = 1'b0;
            end
            @(posedge clk);
            #1;
            chk("midrst_no_done", done, 0);
            chk("midrst_idle", busy, 0);
        end
        run_txn(24'h018002, 3, 2, 2, 32'h0000C33C, 0, dk);
        chk("post_rst_rx_buf", rx_buf[15:0], 16'hC33C);

        for (int i = 0; i < 8; i++) begin
            n = $urandom_range(1, 3);
            rl = $urandom_range(0, 7);
            r = rl > 4 ? 4 : rl;
            d = $urandom_range(0, r);
            run_txn(24'($urandom), n, rl, d, $urandom, bit'($urandom_range(0, 1)), dk);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
